// File: rtl/delay_window.sv
// Line-buffer window generator: emits a vertical column of HEIGHT_NB pixels per
// accepted input pixel, with valid/ready flow control, priming and end-of-line marking.
module delay_window_line #(
   parameter int AW    = 12,
   parameter int DEPTH = 1 << AW,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];

   // Asynchronous read gives read-first behaviour against the clocked write.
   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end
endmodule

module delay_window #(
   parameter int HEIGHT_NB  = 3,
   parameter int CHAN_NB    = 1,
   parameter int IMG_WIDTH  = 8,
   parameter int MEM_AWIDTH = 12,
   parameter int MEM_DEPTH  = 1 << MEM_AWIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [MEM_AWIDTH-1:0]                 cfg_width,
   input  logic                                  cfg_set,
   input  logic [CHAN_NB*IMG_WIDTH-1:0]          up_data,
   input  logic                                  up_val,
   output logic                                  up_rdy,
   output logic [HEIGHT_NB*CHAN_NB*IMG_WIDTH-1:0] dn_data,
   output logic                                  dn_val,
   input  logic                                  dn_rdy,
   output logic                                  dn_last
);
   localparam int PW = CHAN_NB * IMG_WIDTH;
   localparam int FW = $clog2(HEIGHT_NB);
   localparam logic [FW-1:0]         FILL_MAX  = FW'(HEIGHT_NB - 1);
   localparam logic [MEM_AWIDTH-1:0] WIDTH_RST = MEM_AWIDTH'(MEM_DEPTH - 1);

   logic [MEM_AWIDTH-1:0]          col, width;
   logic [FW-1:0]                  fill;
   logic [HEIGHT_NB-1:0][PW-1:0]   r;
   logic [HEIGHT_NB-1:0][PW-1:0]   dn_q;
   logic                           acc, eol;

   assign up_rdy  = ~cfg_set & (~dn_val | dn_rdy);
   assign acc     = up_val & up_rdy;
   assign eol     = (col == width);
   assign r[0]    = up_data;
   assign dn_data = dn_q;

   // Line h-1 stores row h-1 and returns it one line later as row h.
   for (genvar h = 1; h < HEIGHT_NB; h++) begin : g_line
      delay_window_line #(
         .AW   (MEM_AWIDTH),
         .DEPTH(MEM_DEPTH),
         .DW   (PW)
      ) u_line (
         .clk  (clk),
         .we   (acc),
         .addr (col),
         .wdata(r[h-1]),
         .rdata(r[h])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn_q    <= '0;
         dn_val  <= 1'b0;
         dn_last <= 1'b0;
         col     <= '0;
         fill    <= '0;
         width   <= WIDTH_RST;
      end else if (cfg_set) begin
         width   <= cfg_width;
         col     <= '0;
         fill    <= '0;
         dn_val  <= 1'b0;
         dn_last <= 1'b0;
      end else if (acc) begin
         dn_q    <= r;
         dn_last <= eol;
         // Output only once every row of the column holds real line data.
         dn_val  <= (fill == FILL_MAX);
         if (eol) begin
            col <= '0;
            if (fill != FILL_MAX) fill <= fill + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end else if (dn_rdy) begin
         dn_val <= 1'b0;
      end
   end
endmodule

// File: tb/tb_delay_window.sv
// Directed bench for delay_window: priming, line end, backpressure, reconfig,
// async reset, lane independence and one-pixel lines.
module tb_delay_window;
   localparam int H = 3, C = 2, W = 8, AW = 4;
   localparam int DW = H * C * W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] cfg_width = '0;
   logic          cfg_set = 1'b0;
   logic [C*W-1:0] up_data = '0;
   logic          up_val = 1'b0;
   logic          up_rdy;
   logic [DW-1:0] dn_data;
   logic          dn_val;
   logic          dn_rdy = 1'b1;
   logic          dn_last;

   int checks = 0;
   int errors = 0;

   delay_window #(
      .HEIGHT_NB(H), .CHAN_NB(C), .IMG_WIDTH(W), .MEM_AWIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_set(cfg_set),
      .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
      .dn_data(dn_data), .dn_val(dn_val), .dn_rdy(dn_rdy), .dn_last(dn_last)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pix(input int l, input int c);
      return 8'(l * 16 + c);
   endfunction

   function automatic logic [15:0] lanes(input int l, input int c, input bit inv);
      logic [7:0] p;
      p = pix(l, c);
      return {inv ? ~p : p, p};
   endfunction

   // Column for pixel (l,c): row h holds line l-h at the same column.
   function automatic logic [DW-1:0] col_exp(input int l, input int c, input bit inv);
      logic [DW-1:0] v;
      v = '0;
      for (int h = 0; h < H; h++) v[h*16 +: 16] = lanes(l - h, c, inv);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic accept(input int l, input int c, input bit inv);
      up_data = lanes(l, c, inv);
      up_val  = 1'b1;
      @(posedge clk); #1;
      up_val  = 1'b0;
   endtask

   task automatic configure(input logic [AW-1:0] w);
      cfg_set   = 1'b1;
      cfg_width = w;
      up_val    = 1'b1;
      #1 chk("cfg_up_rdy", DW'(up_rdy), DW'(0));
      @(posedge clk); #1;
      cfg_set = 1'b0;
      up_val  = 1'b0;
      chk("cfg_dn_val", DW'(dn_val), DW'(0));
   endtask

   initial begin
      // Reset
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_val", DW'(dn_val), DW'(0));
      chk("rst_last", DW'(dn_last), DW'(0));
      chk("rst_data", dn_data, DW'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1. Priming
      configure(4'd3);
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < 4; c++) begin
            accept(l, c, 1'b0);
            chk("prime_val", DW'(dn_val), DW'(0));
         end
      accept(2, 0, 1'b0);
      chk("first_val", DW'(dn_val), DW'(1));
      chk("first_data", dn_data, col_exp(2, 0, 1'b0));
      chk("first_last", DW'(dn_last), DW'(0));

      // 2. Line end
      for (int c = 1; c < 4; c++) begin
         accept(2, c, 1'b0);
         chk("l2_val", DW'(dn_val), DW'(1));
         chk("l2_data", dn_data, col_exp(2, c, 1'b0));
         chk("l2_last", DW'(dn_last), DW'(c == 3));
      end
      accept(3, 0, 1'b0);
      chk("l3c0_data", dn_data, col_exp(3, 0, 1'b0));
      chk("l3c0_last", DW'(dn_last), DW'(0));

      // 3. Backpressure
      dn_rdy  = 1'b0;
      up_data = lanes(3, 1, 1'b0);
      up_val  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_up_rdy", DW'(up_rdy), DW'(0));
         @(posedge clk); #1;
         chk("bp_val", DW'(dn_val), DW'(1));
         chk("bp_data", dn_data, col_exp(3, 0, 1'b0));
      end
      dn_rdy = 1'b1;
      accept(3, 1, 1'b0);
      chk("bp_resume", dn_data, col_exp(3, 1, 1'b0));
      chk("bp_resume_val", DW'(dn_val), DW'(1));

      // 4. Reconfig mid-line to 2-pixel lines
      up_data = lanes(3, 2, 1'b0);
      configure(4'd1);
      for (int l = 4; l < 6; l++)
         for (int c = 0; c < 2; c++) begin
            accept(l, c, 1'b0);
            chk("rcfg_prime", DW'(dn_val), DW'(0));
         end
      accept(6, 0, 1'b0);
      chk("rcfg_val", DW'(dn_val), DW'(1));
      chk("rcfg_data", dn_data, col_exp(6, 0, 1'b0));

      // 5. Async reset between edges
      #2 rst_n = 1'b0;
      #1;
      chk("arst_val", DW'(dn_val), DW'(0));
      chk("arst_last", DW'(dn_last), DW'(0));
      chk("arst_data", dn_data, DW'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int l = 7; l < 9; l++)
         for (int c = 0; c < 16; c++) begin
            accept(l, c, 1'b0);
            chk("arst_prime", DW'(dn_val), DW'(0));
         end
      for (int c = 0; c < 16; c++) begin
         accept(9, c, 1'b0);
         chk("w15_val", DW'(dn_val), DW'(1));
         chk("w15_data", dn_data, col_exp(9, c, 1'b0));
         chk("w15_last", DW'(dn_last), DW'(c == 15));
      end

      // 6. Channel independence
      configure(4'd3);
      for (int l = 10; l < 12; l++)
         for (int c = 0; c < 4; c++) accept(l, c, 1'b1);
      for (int c = 0; c < 4; c++) begin
         accept(12, c, 1'b1);
         chk("lane_data", dn_data, col_exp(12, c, 1'b1));
      end

      // 7. One-pixel lines
      configure(4'd0);
      accept(13, 0, 1'b0);
      chk("w0_prime1", DW'(dn_val), DW'(0));
      accept(14, 0, 1'b0);
      chk("w0_prime2", DW'(dn_val), DW'(0));
      accept(15, 0, 1'b0);
      chk("w0_val", DW'(dn_val), DW'(1));
      chk("w0_data", dn_data, col_exp(15, 0, 1'b0));
      chk("w0_last", DW'(dn_last), DW'(1));

      // Drain: no new pixel, so dn_val clears after the handshake.
      @(posedge clk); #1;
      chk("drain_val", DW'(dn_val), DW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
